// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front end and the transaction controller.
// Holds the state encodings, the BCD digit width and the default PIN length.
package atm_pkg;

    localparam int BCD_W          = 4;
    localparam int PIN_DIGITS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        REPORT,
        HOLD
    } pin_state_t;

    // Transaction controller states; PIN_CHECK consumes pin_entered/pin_valid.
    typedef enum logic [2:0] {
        CTRL_IDLE,
        CTRL_PIN_CHECK,
        CTRL_MENU,
        CTRL_DISPENSE,
        CTRL_EJECT
    } ctrl_state_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_pin_digit_buffer.sv
// PIN digit shift register with occupancy count; first digit ends up in the MSBs.
// Load/clear take effect on the next edge; loads into a full buffer are ignored.
module atm_pin_digit_buffer
    import atm_pkg::*;
#(
    parameter int DIGITS = PIN_DIGITS_DEF,
    parameter int CNT_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W-1:0]        digit,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic [BCD_W*DIGITS-1:0] pin
);

    localparam int PIN_W = BCD_W * DIGITS;

    logic [PIN_W-1:0] pin_q;
    logic [CNT_W-1:0] cnt_q;

    assign full  = (cnt_q == CNT_W'(DIGITS));
    assign count = cnt_q;
    assign pin   = pin_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pin_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            // Zero the digits too so a PIN never lingers after a session.
            pin_q <= '0;
            cnt_q <= '0;
        end else if (load && !full) begin
            pin_q <= {pin_q[PIN_W-BCD_W-1:0], digit};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/atm_pin_entry.sv
// Keypad PIN entry: collects digits, compares against the card PIN, tracks retries/lock.
// Result pulse appears the cycle after edge N+2 for key_enter at edge N; keys are never stalled.
module atm_pin_entry
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS     = PIN_DIGITS_DEF,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        card_insert,
    input  logic                        key_valid,
    input  logic [BCD_W-1:0]            key_digit,
    input  logic                        key_clear,
    input  logic                        key_enter,
    input  logic [BCD_W*PIN_DIGITS-1:0] stored_pin,
    input  logic                        admin_unlock,
    output logic                        pin_entered,
    output logic                        pin_valid,
    output logic                        key_error,
    output logic [2:0]                  digit_count,
    output logic [1:0]                  retries_left,
    output logic                        card_locked
);

    localparam int              TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      R_MAX  = 2'(MAX_TRIES);

    pin_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          result_q, result_d;
    logic          pin_entered_d, pin_valid_d, key_error_d;
    logic [1:0]    retries_d;
    logic          locked_d;
    logic          buf_clr, buf_load, buf_full;
    logic [BCD_W*PIN_DIGITS-1:0] buf_pin;

    atm_pin_digit_buffer #(
        .DIGITS (PIN_DIGITS),
        .CNT_W  (3)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (buf_clr),
        .load  (buf_load),
        .digit (key_digit),
        .count (digit_count),
        .full  (buf_full),
        .pin   (buf_pin)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        result_d      = result_q;
        pin_entered_d = 1'b0;
        pin_valid_d   = 1'b0;
        key_error_d   = 1'b0;
        retries_d     = retries_left;
        locked_d      = card_locked;
        buf_clr       = 1'b0;
        buf_load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (card_insert) begin
                    state_d = COLLECT;
                    timer_d = '0;
                    buf_clr = 1'b1;
                end
            end
            COLLECT: begin
                // Card removal aborts silently and outranks any key this cycle.
                if (!card_insert) begin
                    state_d = IDLE;
                    buf_clr = 1'b1;
                end else if (key_clear) begin
                    buf_clr = 1'b1;
                    timer_d = '0;
                end else if (key_enter) begin
                    timer_d = '0;
                    if (buf_full) state_d = CHECK;
                    else          key_error_d = 1'b1;
                end else if (key_valid) begin
                    timer_d = '0;
                    if (is_bcd(key_digit) && !buf_full) buf_load    = 1'b1;
                    else                                 key_error_d = 1'b1;
                end else if (timer_q == T_LAST) begin
                    state_d  = REPORT;
                    result_d = 1'b0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                result_d = (buf_pin == stored_pin) && !card_locked;
                state_d  = REPORT;
            end
            REPORT: begin
                pin_entered_d = 1'b1;
                pin_valid_d   = result_q;
                if (result_q) begin
                    retries_d = R_MAX;
                end else begin
                    if (retries_left != 2'd0) retries_d = retries_left - 2'd1;
                    if (retries_left <= 2'd1) locked_d  = 1'b1;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (!card_insert) begin
                    state_d = IDLE;
                    buf_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Unlock overrides any failure bookkeeping done above in the same cycle.
        if (admin_unlock) begin
            locked_d  = 1'b0;
            retries_d = R_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            result_q     <= 1'b0;
            pin_entered  <= 1'b0;
            pin_valid    <= 1'b0;
            key_error    <= 1'b0;
            retries_left <= R_MAX;
            card_locked  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            result_q     <= result_d;
            pin_entered  <= pin_entered_d;
            pin_valid    <= pin_valid_d;
            key_error    <= key_error_d;
            retries_left <= retries_d;
            card_locked  <= locked_d;
        end
    end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: directed scenarios plus randomized sessions scored by a
// session-level model (digit queue, retry count, lock flag).
module tb_atm_pin_entry;

    localparam int PD = 4;
    localparam int MT = 3;
    localparam int TO = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          card_insert, key_valid, key_clear, key_enter, admin_unlock;
    logic [3:0]    key_digit;
    logic [4*PD-1:0] stored_pin;
    logic          pin_entered, pin_valid, key_error, card_locked;
    logic [2:0]    digit_count;
    logic [1:0]    retries_left;

    always #5 clk = ~clk;

    atm_pin_entry #(
        .PIN_DIGITS     (PD),
        .MAX_TRIES      (MT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .card_insert  (card_insert),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .key_clear    (key_clear),
        .key_enter    (key_enter),
        .stored_pin   (stored_pin),
        .admin_unlock (admin_unlock),
        .pin_entered  (pin_entered),
        .pin_valid    (pin_valid),
        .key_error    (key_error),
        .digit_count  (digit_count),
        .retries_left (retries_left),
        .card_locked  (card_locked)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: typed digits, remaining attempts, lock flag.
    int m_q[$];
    int m_retries = MT;
    bit m_locked  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_match();
        if (m_q.size() != PD) return 1'b0;
        for (int i = 0; i < PD; i++)
            if (m_q[i] != int'(stored_pin[(PD-1-i)*4 +: 4])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_result(input bit pass);
        if (pass) m_retries = MT;
        else begin
            if (m_retries > 0) m_retries--;
            if (m_retries == 0) m_locked = 1'b1;
        end
    endtask

    task automatic insert();
        card_insert = 1'b1;
        cyc();
        m_q.delete();
        check("insert_count", 32'(digit_count), 32'(0));
    endtask

    task automatic remove();
        card_insert = 1'b0;
        cyc();
        m_q.delete();
        check("remove_nopulse", 32'(pin_entered), 32'(0));
    endtask

    task automatic press(input logic [3:0] d);
        bit exp_err;
        exp_err = (d > 4'd9) || (m_q.size() == PD);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
        if (!exp_err) m_q.push_back(int'(d));
        check("key_error", 32'(key_error), 32'(exp_err));
        check("digit_count", 32'(digit_count), 32'(m_q.size()));
    endtask

    task automatic clear_keys(input bit with_digit);
        key_clear = 1'b1;
        key_valid = with_digit;
        key_digit = 4'd7;
        cyc();
        key_clear = 1'b0;
        key_valid = 1'b0;
        m_q.delete();
        check("clear_count", 32'(digit_count), 32'(0));
        check("clear_noerr", 32'(key_error), 32'(0));
    endtask

    task automatic enter(output bit reported);
        bit full, exp_pass;
        full = (m_q.size() == PD);
        key_enter = 1'b1;
        cyc();
        key_enter = 1'b0;
        reported = full;
        check("enter_err", 32'(key_error), 32'(!full));
        check("enter_nopulse", 32'(pin_entered), 32'(0));
        if (!full) begin
            cyc();
            check("short_nopulse", 32'(pin_entered), 32'(0));
        end else begin
            exp_pass = model_match() && !m_locked;
            cyc();
            check("check_nopulse", 32'(pin_entered), 32'(0));
            cyc();
            check("pin_entered", 32'(pin_entered), 32'(1));
            check("pin_valid", 32'(pin_valid), 32'(exp_pass));
            model_result(exp_pass);
            check("retries_left", 32'(retries_left), 32'(m_retries));
            check("card_locked", 32'(card_locked), 32'(m_locked));
            cyc();
            check("pulse_width", 32'(pin_entered), 32'(0));
        end
    endtask

    task automatic type_pin(input logic [15:0] p);
        for (int i = 0; i < PD; i++) press(p[(PD-1-i)*4 +: 4]);
    endtask

    initial begin
        bit done;
        int n, steps, r, idx;
        logic [3:0] d;

        rst = 1'b0; card_insert = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
        key_enter = 1'b0; admin_unlock = 1'b0; key_digit = 4'd0; stored_pin = 16'h1234;
        cyc(); cyc();
        rst = 1'b1;
        check("rst_pin_entered", 32'(pin_entered), 32'(0));
        check("rst_pin_valid", 32'(pin_valid), 32'(0));
        check("rst_key_error", 32'(key_error), 32'(0));
        check("rst_digit_count", 32'(digit_count), 32'(0));
        check("rst_retries", 32'(retries_left), 32'(MT));
        check("rst_locked", 32'(card_locked), 32'(0));

        // Keys with no card are ignored.
        key_valid = 1'b1; key_digit = 4'd5; key_enter = 1'b1;
        cyc();
        key_valid = 1'b0; key_enter = 1'b0;
        check("idle_key_noerr", 32'(key_error), 32'(0));
        check("idle_key_count", 32'(digit_count), 32'(0));

        // Correct PIN.
        insert(); type_pin(16'h1234); enter(done); remove();

        // Three wrong sessions lock the card; a correct PIN then still fails.
        for (int s = 0; s < 3; s++) begin
            insert(); type_pin(16'h1235); enter(done); remove();
        end
        insert(); type_pin(16'h1234); enter(done); remove();

        admin_unlock = 1'b1; cyc(); admin_unlock = 1'b0;
        m_locked = 1'b0; m_retries = MT;
        check("unlock_locked", 32'(card_locked), 32'(0));
        check("unlock_retries", 32'(retries_left), 32'(MT));

        // Short enter, bad digit, overflow digit, then a full correct PIN.
        insert();
        press(4'd1); press(4'd2); enter(done);
        press(4'hA); press(4'd3); press(4'd4); press(4'd5);
        enter(done); remove();

        // Clear beats a simultaneous digit.
        insert(); press(4'd9); press(4'd9); clear_keys(1'b1);
        type_pin(16'h1234); enter(done); remove();

        // Idle timeout reports a failure.
        insert();
        n = 0;
        while (!pin_entered && n < TO + 100) begin cyc(); n++; end
        check("timeout_latency", 32'(n), 32'(TO + 1));
        check("timeout_valid", 32'(pin_valid), 32'(0));
        model_result(1'b0);
        check("timeout_retries", 32'(retries_left), 32'(m_retries));
        remove();

        // Card pulled mid-entry: no result, counters untouched.
        insert(); press(4'd1); press(4'd2); remove();
        for (int i = 0; i < 3; i++) cyc();
        check("pull_nopulse", 32'(pin_entered), 32'(0));
        check("pull_retries", 32'(retries_left), 32'(m_retries));

        // Reset while in CHECK aborts the pending result.
        insert(); type_pin(16'h1234);
        key_enter = 1'b1; cyc(); key_enter = 1'b0;
        rst = 1'b0; cyc(); rst = 1'b1;
        m_q.delete(); m_retries = MT; m_locked = 1'b0;
        check("ckrst_pin_entered", 32'(pin_entered), 32'(0));
        check("ckrst_pin_valid", 32'(pin_valid), 32'(0));
        check("ckrst_key_error", 32'(key_error), 32'(0));
        check("ckrst_digit_count", 32'(digit_count), 32'(0));
        check("ckrst_retries", 32'(retries_left), 32'(MT));
        check("ckrst_locked", 32'(card_locked), 32'(0));
        cyc();
        check("ckrst_nopulse", 32'(pin_entered), 32'(0));
        remove();

        // Randomized sessions.
        for (int s = 0; s < 60; s++) begin
            if (m_locked && $urandom_range(0, 3) == 0) begin
                admin_unlock = 1'b1; cyc(); admin_unlock = 1'b0;
                m_locked = 1'b0; m_retries = MT;
                check("rnd_unlock", 32'(card_locked), 32'(0));
            end
            for (int i = 0; i < PD; i++) stored_pin[i*4 +: 4] = 4'($urandom_range(0, 9));
            insert();
            done = 1'b0;
            steps = 0;
            while (!done && steps < 12) begin
                r = $urandom_range(0, 9);
                if (r < 7) begin
                    idx = m_q.size();
                    if (idx < PD && $urandom_range(0, 3) != 0) d = stored_pin[(PD-1-idx)*4 +: 4];
                    else d = 4'($urandom_range(0, 15));
                    press(d);
                end else if (r == 7) begin
                    clear_keys(1'b0);
                end else begin
                    enter(done);
                end
                steps++;
            end
            remove();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
